// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit for the E stage.
// Owns HI/LO; result is computed at issue and committed after a fixed delay.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] tmp_hi_q;
    logic [31:0] tmp_lo_q;
    logic        wr_q;

    logic [31:0] tmp_hi_d;
    logic [31:0] tmp_lo_d;
    logic        wr_d;
    logic [7:0]  cnt_d;

    logic               is_mul;
    logic               is_div;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_sgn;
    logic        [31:0] dvd;
    logic        [31:0] dvs;
    logic        [31:0] dvs_safe;
    logic        [31:0] quo;
    logic        [31:0] rem;
    logic        [31:0] quo_fin;
    logic        [31:0] rem_fin;

    assign is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);

    assign busy  = (state_q == RUN);
    assign start = (is_mul || is_div) && !busy;
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        md_out = 32'd0;
        if (md_op == OP_MFHI) begin
            md_out = hi_q;
        end else if (md_op == OP_MFLO) begin
            md_out = lo_q;
        end
    end

    assign prod_s = $signed({{32{rs_data[31]}}, rs_data})
                  * $signed({{32{rt_data[31]}}, rt_data});
    assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

    // Signed divide on magnitudes, so INT_MIN / -1 wraps to INT_MIN.
    assign div_sgn  = (md_op == OP_DIV);
    assign dvd      = (div_sgn && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
    assign dvs      = (div_sgn && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;
    assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    assign quo      = dvd / dvs_safe;
    assign rem      = dvd % dvs_safe;
    assign quo_fin  = (div_sgn && (rs_data[31] ^ rt_data[31])) ? (~quo + 32'd1) : quo;
    assign rem_fin  = (div_sgn && rs_data[31]) ? (~rem + 32'd1) : rem;

    always_comb begin
        tmp_hi_d = 32'd0;
        tmp_lo_d = 32'd0;
        wr_d     = 1'b1;
        cnt_d    = 8'(MULT_CYCLES);
        case (md_op)
            OP_MULT: begin
                tmp_hi_d = prod_s[63:32];
                tmp_lo_d = prod_s[31:0];
            end
            OP_MULTU: begin
                tmp_hi_d = prod_u[63:32];
                tmp_lo_d = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                tmp_hi_d = rem_fin;
                tmp_lo_d = quo_fin;
                wr_d     = (rt_data != 32'd0);
                cnt_d    = 8'(DIV_CYCLES);
            end
            default: begin
                tmp_hi_d = 32'd0;
                tmp_lo_d = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
            wr_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tmp_hi_q <= tmp_hi_d;
                        tmp_lo_q <= tmp_lo_d;
                        wr_q     <= wr_d;
                        cnt_q    <= cnt_d;
                        state_q  <= RUN;
                    end else if (md_op == OP_MTHI) begin
                        hi_q <= rs_data;
                    end else if (md_op == OP_MTLO) begin
                        lo_q <= rs_data;
                    end
                end
                RUN: begin
                    if (cnt_q == 8'd1) begin
                        if (wr_q) begin
                            hi_q <= tmp_hi_q;
                            lo_q <= tmp_lo_q;
                        end
                        cnt_q   <= 8'd0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes md_op plus forwarded rs/rt operand values produced by the E-stage controller.
- Owns the HI/LO registers and supplies mfhi/mflo data to the E-stage result mux.
- Exposes start/busy so the D-stage hazard logic can stall md-class instructions while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..255).
- DIV_CYCLES, 10, busy cycles for div/divu (1..255).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- md_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9..15 treated as none.
- rs_data  in  32  forwarded rs operand; dividend or multiplicand, and source for mthi/mtlo.
- rt_data  in  32  forwarded rt operand; divisor or multiplier.
- start  out  1  combinational; 1 when md_op is 1..4 and busy=0.
- busy  out  1  registered; 1 while an operation is in flight.
- hi  out  32  current HI register.
- lo  out  32  current LO register.
- md_out  out  32  combinational; hi when md_op=5, lo when md_op=6, else 0.

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, cycle counter=0, result temporaries=0. Outputs reflect this immediately, not at the next edge.
- State machine has two states, IDLE (busy=0) and RUN (busy=1).
- IDLE accepting a start: when md_op in 1..4 at a rising edge, latch the full 64-bit result into internal temporaries, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN.
- RUN: the counter decrements each edge. At the edge where the counter is 1, copy the temporaries into HI/LO, set busy=0 and return to IDLE.
- Latency: for an op issued in cycle 0, busy=1 in cycles 1..N and the new HI/LO are visible in cycle N+1 with busy=0.
- HI/LO are never modified while busy=1.
- mult: signed 32x32 to 64. HI = upper 32 bits, LO = lower 32 bits.
- multu: same split, unsigned operands.
- div: LO = quotient truncated toward zero; HI = remainder, sign follows the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient in LO, remainder in HI.
- Divide by zero (rt_data=0, div or divu): the unit still goes busy for DIV_CYCLES, and HI/LO are left unchanged at completion.
- mthi/mtlo in IDLE: write rs_data into HI or LO at the edge; the value is readable the next cycle.
- mthi/mtlo while busy=1: ignored. The hazard unit must never issue them while busy.
- md_op 1..4 while busy=1: ignored; no restart and no counter reload.
- mfhi/mflo: md_out reads the current registers and is valid regardless of busy. While busy it returns the pre-operation value; the hazard unit is responsible for stalling mfhi/mflo behind an in-flight op.
- Back-to-back ops: a start in the first cycle with busy=0 after completion is accepted.
- Reset mid-operation aborts the op. Busy drops and HI/LO clear; the pending result is discarded.
- Fixed stage contract: D-stage stall condition = (D instr is md-class) & (start | busy).

Test Plan:
- mult, rs=0xFFFFFFFF, rt=2 → busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu → HI=0x00000001, LO=0xFFFFFFFE.
- div, rs=0xFFFFFFF9 (-7), rt=2 → busy=1 for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu, rs=7, rt=2 → LO=3, HI=1.
- mthi, rs=0x00001234, then mfhi next cycle → md_out=0x00001234. Then div by zero → after 10 busy cycles HI=0x00001234, LO unchanged.
- mult issued, then mtlo with rs=0xDEAD and a second mult while busy → both ignored; final HI/LO equal the first mult result; busy falls after exactly 5 cycles.
- Start a div, then drive reset=0 during busy cycle 4 → busy=0 and HI=LO=0 immediately. After reset release, no HI/LO update ever occurs.
- Completing mult, then mult with rs=3, rt=4 in the first idle cycle → accepted, start=1 that cycle, LO=12 five cycles later.
